// File: rtl/avalon_cmd_master.sv
// avalon_cmd_master: single-outstanding command/response to Avalon-MM master with checking and timeout
module avalon_cmd_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    input  logic [3:0]  CMD_BE,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] ADDRESS,
    output logic        READ,
    output logic        WRITE,
    output logic [31:0] WRITEDATA,
    output logic [3:0]  BYTE_ENABLE,
    output logic        BEGINTRANSFER,
    output logic        LOCK,
    output logic [2:0]  BURSTCOUNT,
    output logic        BEGINBURSTTRANSFER,
    input  logic        WAITREQUEST,
    input  logic [31:0] READDATA,
    input  logic        READDATAVALID
);
    typedef enum logic [1:0] {IDLE, BUS, RDWAIT, RESP} state_t;

    state_t            state, nxt;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              read_d, write_d, bt_d, rsp_valid_d, err_d;
    logic [31:0]       addr_d, wdata_d, rdata_d;
    logic [3:0]        be_d;
    logic              expired;

    assign LOCK = 1'b0;
    assign BURSTCOUNT = 3'd1;
    assign BEGINBURSTTRANSFER = BEGINTRANSFER;
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    // Next state and next values of every registered output
    always_comb begin
        nxt = state;
        cnt_d = cnt;
        read_d = READ;
        write_d = WRITE;
        addr_d = ADDRESS;
        wdata_d = WRITEDATA;
        be_d = BYTE_ENABLE;
        bt_d = 1'b0;
        rsp_valid_d = RSP_VALID;
        rdata_d = RSP_RDATA;
        err_d = RSP_ERR;
        case (state)
            IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    if (CMD_ADDR[1:0] != 2'b00 || (CMD_WRITE && CMD_BE == 4'h0)) begin
                        nxt = RESP;
                        rsp_valid_d = 1'b1;
                        err_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        nxt = BUS;
                        addr_d = CMD_ADDR;
                        wdata_d = CMD_WDATA;
                        be_d = CMD_BE;
                        read_d = !CMD_WRITE;
                        write_d = CMD_WRITE;
                        bt_d = 1'b1;
                        cnt_d = '0;
                    end
                end
            end
            BUS: begin
                if (!WAITREQUEST) begin
                    read_d = 1'b0;
                    write_d = 1'b0;
                    cnt_d = '0;
                    if (WRITE || READDATAVALID) begin
                        nxt = RESP;
                        rsp_valid_d = 1'b1;
                        err_d = 1'b0;
                        rdata_d = WRITE ? 32'h0 : READDATA;
                    end else begin
                        nxt = RDWAIT;
                    end
                end else if (expired) begin
                    read_d = 1'b0;
                    write_d = 1'b0;
                    nxt = RESP;
                    rsp_valid_d = 1'b1;
                    err_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RDWAIT: begin
                if (READDATAVALID || expired) begin
                    nxt = RESP;
                    rsp_valid_d = 1'b1;
                    err_d = !READDATAVALID;
                    rdata_d = READDATAVALID ? READDATA : 32'h0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                if (RSP_READY) begin
                    nxt = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset discards any transfer in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt <= '0;
            CMD_READY <= 1'b0;
            READ <= 1'b0;
            WRITE <= 1'b0;
            ADDRESS <= '0;
            WRITEDATA <= '0;
            BYTE_ENABLE <= '0;
            BEGINTRANSFER <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= cnt_d;
            CMD_READY <= (nxt == IDLE);
            READ <= read_d;
            WRITE <= write_d;
            ADDRESS <= addr_d;
            WRITEDATA <= wdata_d;
            BYTE_ENABLE <= be_d;
            BEGINTRANSFER <= bt_d;
            RSP_VALID <= rsp_valid_d;
            RSP_RDATA <= rdata_d;
            RSP_ERR <= err_d;
        end
    end
endmodule

// File: tb/tb_avalon_cmd_master.sv
// tb_avalon_cmd_master: directed tests against a small Avalon memory slave model
module tb_avalon_cmd_master;
    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_VALID = 1'b0, CMD_WRITE = 1'b0;
    logic [31:0] CMD_ADDR = '0, CMD_WDATA = '0;
    logic [3:0]  CMD_BE = '0;
    logic        RSP_READY = 1'b1;
    logic        CMD_READY, RSP_VALID, RSP_ERR, READ, WRITE, BEGINTRANSFER, LOCK, BEGINBURSTTRANSFER;
    logic [31:0] RSP_RDATA, ADDRESS, WRITEDATA, READDATA;
    logic [3:0]  BYTE_ENABLE;
    logic [2:0]  BURSTCOUNT;
    logic        WAITREQUEST, READDATAVALID;

    int checks = 0, errors = 0;
    int ws = 0, lat = 0, wcnt = 0, rcnt = 0;
    logic        force_rdv = 1'b0;
    logic [3:0]  raddr = '0;
    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    avalon_cmd_master dut (
        .CLK(clk), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_BE(CMD_BE),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .ADDRESS(ADDRESS), .READ(READ), .WRITE(WRITE), .WRITEDATA(WRITEDATA),
        .BYTE_ENABLE(BYTE_ENABLE), .BEGINTRANSFER(BEGINTRANSFER), .LOCK(LOCK),
        .BURSTCOUNT(BURSTCOUNT), .BEGINBURSTTRANSFER(BEGINBURSTTRANSFER),
        .WAITREQUEST(WAITREQUEST), .READDATA(READDATA), .READDATAVALID(READDATAVALID)
    );

    // Slave: ws wait states per transfer; read data lat cycles after acceptance (0 = same cycle, <0 = never)
    assign WAITREQUEST = (READ || WRITE) && (wcnt < ws);
    assign READDATAVALID = (READ && !WAITREQUEST && lat == 0) || (rcnt == 1) || force_rdv;
    assign READDATA = (rcnt == 1) ? mem[raddr] : mem[ADDRESS[5:2]];

    always @(posedge clk) begin
        if (WRITE && !WAITREQUEST)
            for (int i = 0; i < 4; i++)
                if (BYTE_ENABLE[i]) mem[ADDRESS[5:2]][8*i+:8] <= WRITEDATA[8*i+:8];
        wcnt <= ((READ || WRITE) && WAITREQUEST) ? wcnt + 1 : 0;
        if (READ && !WAITREQUEST && lat > 0) begin
            rcnt <= lat;
            raddr <= ADDRESS[5:2];
        end else if (rcnt > 0) begin
            rcnt <= rcnt - 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        CMD_VALID = 1'b1;
        CMD_WRITE = w;
        CMD_ADDR = a;
        CMD_WDATA = d;
        CMD_BE = be;
        tick();
        CMD_VALID = 1'b0;
    endtask

    // Issues one command and waits for its response; lt = cycles from acceptance to RSP_VALID
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int lt, output logic [31:0] rd, output logic er);
        drive(w, a, d, be);
        lt = 1;
        while (!RSP_VALID && lt < 100) begin
            tick();
            lt++;
        end
        checks++;
        if (RSP_VALID !== 1'b1) begin
            errors++;
            $display("FAIL rsp_wait no response got %b exp 1", RSP_VALID);
        end
        rd = RSP_RDATA;
        er = RSP_ERR;
        tick();
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++;
        if ({CMD_READY, RSP_VALID, READ, WRITE, BEGINTRANSFER, RSP_ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 000000", {CMD_READY, RSP_VALID, READ, WRITE, BEGINTRANSFER, RSP_ERR});
        end
        checks++;
        if ({ADDRESS, WRITEDATA, RSP_RDATA, BYTE_ENABLE} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {ADDRESS, WRITEDATA, RSP_RDATA, BYTE_ENABLE});
        end
        checks++;
        if ({LOCK, BURSTCOUNT} !== 4'b0001) begin
            errors++;
            $display("FAIL tieoffs got %b exp 0001", {LOCK, BURSTCOUNT});
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", CMD_READY);
        end
    endtask

    task automatic test_write_read;
        int lt;
        logic [31:0] rd;
        logic er;
        drive(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        checks++;
        if ({WRITE, READ, BEGINTRANSFER, BEGINBURSTTRANSFER, RSP_VALID, CMD_READY} !== 6'b101100) begin
            errors++;
            $display("FAIL wr_bus_ctl got %b exp 101100", {WRITE, READ, BEGINTRANSFER, BEGINBURSTTRANSFER, RSP_VALID, CMD_READY});
        end
        checks++;
        if ({ADDRESS, WRITEDATA, BYTE_ENABLE} !== {32'h4, 32'hDEADBEEF, 4'hF}) begin
            errors++;
            $display("FAIL wr_bus_data got %h exp %h", {ADDRESS, WRITEDATA, BYTE_ENABLE}, {32'h4, 32'hDEADBEEF, 4'hF});
        end
        tick();
        checks++;
        if ({WRITE, BEGINTRANSFER, RSP_VALID, RSP_ERR} !== 4'b0010 || RSP_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL wr_rsp got %b/%h exp 0010/0", {WRITE, BEGINTRANSFER, RSP_VALID, RSP_ERR}, RSP_RDATA);
        end
        tick();
        checks++;
        if ({RSP_VALID, CMD_READY} !== 2'b01) begin
            errors++;
            $display("FAIL wr_idle got %b exp 01", {RSP_VALID, CMD_READY});
        end
        do_cmd(1'b0, 32'h4, 32'h0, 4'hF, lt, rd, er);
        checks++;
        if (lt !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL rd_back got lat %0d data %h err %b exp 2 deadbeef 0", lt, rd, er);
        end
    endtask

    task automatic test_byte_write;
        int lt;
        logic [31:0] rd;
        logic er;
        do_cmd(1'b1, 32'h8, 32'h11223344, 4'hF, lt, rd, er);
        do_cmd(1'b1, 32'h8, 32'h00AB0000, 4'b0100, lt, rd, er);
        checks++;
        if (lt !== 2 || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_wr got lat %0d err %b exp 2 0", lt, er);
        end
        do_cmd(1'b0, 32'h8, 32'h0, 4'hF, lt, rd, er);
        checks++;
        if (rd !== 32'h11AB3344) begin
            errors++;
            $display("FAIL byte_rd got %h exp 11ab3344", rd);
        end
    endtask

    task automatic test_waitrequest;
        ws = 3;
        drive(1'b0, 32'h4, 32'h0, 4'hF);
        checks++;
        if ({READ, BEGINTRANSFER, WAITREQUEST} !== 3'b111) begin
            errors++;
            $display("FAIL ws_first got %b exp 111", {READ, BEGINTRANSFER, WAITREQUEST});
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++;
            if ({READ, BEGINTRANSFER, RSP_VALID} !== 3'b100 || ADDRESS !== 32'h4 || BYTE_ENABLE !== 4'hF) begin
                errors++;
                $display("FAIL ws_hold cycle %0d got %b %h %h exp 100 4 f", k, {READ, BEGINTRANSFER, RSP_VALID}, ADDRESS, BYTE_ENABLE);
            end
        end
        tick();
        checks++;
        if ({READ, RSP_VALID, RSP_ERR} !== 3'b010 || RSP_RDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ws_rsp got %b %h exp 010 deadbeef", {READ, RSP_VALID, RSP_ERR}, RSP_RDATA);
        end
        tick();
        ws = 0;
    endtask

    task automatic test_read_latency;
        int lt;
        logic [31:0] rd;
        logic er;
        lat = 3;
        do_cmd(1'b0, 32'h8, 32'h0, 4'hF, lt, rd, er);
        checks++;
        if (lt !== 5 || rd !== 32'h11AB3344 || er !== 1'b0) begin
            errors++;
            $display("FAIL rd_lat3 got lat %0d data %h err %b exp 5 11ab3344 0", lt, rd, er);
        end
        lat = 0;
    endtask

    task automatic test_timeout;
        int lt;
        logic [31:0] rd;
        logic er;
        lat = -1;
        do_cmd(1'b0, 32'h4, 32'h0, 4'hF, lt, rd, er);
        checks++;
        if (lt !== 18 || rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL rd_timeout got lat %0d data %h err %b exp 18 0 1", lt, rd, er);
        end
        force_rdv = 1'b1;
        tick();
        force_rdv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({RSP_VALID, CMD_READY} !== 2'b01) begin
                errors++;
                $display("FAIL late_rdv got %b exp 01", {RSP_VALID, CMD_READY});
            end
        end
        lat = 0;
        ws = 100;
        do_cmd(1'b1, 32'hC, 32'h55AA55AA, 4'hF, lt, rd, er);
        checks++;
        if (lt !== 17 || er !== 1'b1 || rd !== 32'h0 || WRITE !== 1'b0) begin
            errors++;
            $display("FAIL wr_timeout got lat %0d err %b data %h wr %b exp 17 1 0 0", lt, er, rd, WRITE);
        end
        ws = 0;
    endtask

    task automatic test_bad(input logic w, input logic [31:0] a, input logic [3:0] be);
        drive(w, a, 32'h12345678, be);
        checks++;
        if ({RSP_VALID, RSP_ERR, READ, WRITE, BEGINTRANSFER} !== 5'b11000 || RSP_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL bad_cmd addr %h got %b %h exp 11000 0", a, {RSP_VALID, RSP_ERR, READ, WRITE, BEGINTRANSFER}, RSP_RDATA);
        end
        tick();
        checks++;
        if ({RSP_VALID, READ, WRITE, CMD_READY} !== 4'b0001) begin
            errors++;
            $display("FAIL bad_after addr %h got %b exp 0001", a, {RSP_VALID, READ, WRITE, CMD_READY});
        end
    endtask

    task automatic test_backpressure;
        RSP_READY = 1'b0;
        drive(1'b0, 32'h8, 32'h0, 4'hF);
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({RSP_VALID, RSP_ERR, CMD_READY} !== 3'b100 || RSP_RDATA !== 32'h11AB3344) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got %b %h exp 100 11ab3344", k, {RSP_VALID, RSP_ERR, CMD_READY}, RSP_RDATA);
            end
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        checks++;
        if ({RSP_VALID, CMD_READY} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got %b exp 01", {RSP_VALID, CMD_READY});
        end
    endtask

    task automatic test_reset_mid;
        ws = 100;
        drive(1'b0, 32'h4, 32'h0, 4'hF);
        tick();
        checks++;
        if (READ !== 1'b1) begin
            errors++;
            $display("FAIL mid_bus got %b exp 1", READ);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if ({READ, RSP_VALID, CMD_READY} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset got %b exp 000", {READ, RSP_VALID, CMD_READY});
        end
        RESET = 1'b0;
        ws = 0;
        tick();
        checks++;
        if ({CMD_READY, RSP_VALID, READ} !== 3'b100) begin
            errors++;
            $display("FAIL mid_recover got %b exp 100", {CMD_READY, RSP_VALID, READ});
        end
    endtask

    task automatic test_back_to_back;
        int lt;
        logic [31:0] rd;
        logic er;
        do_cmd(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, lt, rd, er);
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF, lt, rd, er);
        checks++;
        if (lt !== 2 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL b2b got lat %0d data %h err %b exp 2 cafef00d 0", lt, rd, er);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_waitrequest();
        test_read_latency();
        test_timeout();
        test_bad(1'b0, 32'h6, 4'hF);
        test_bad(1'b1, 32'h10, 4'h0);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
